// File: rtl/rom_region_loader.sv
// Purpose: routes the ioctl download byte stream into NUM_REGIONS ROM regions,
//          packing bytes into BYTES_PER_WORD-wide little-endian words.
// Latency: a word is presented one cycle after its last lane byte (or the flush trigger) is accepted.
// Backpressure: DL_WAIT stalls the byte source while a word is pending or a byte would force a flush;
//               WR_READY low holds the pending word stable.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   DL_ACTIVE/WR/ADDR/DATA  incoming download byte stream (hps_io ioctl side)
//   DL_WAIT               stall request back to the byte source
//   WR_EN/ADDR/DATA/MASK  one-hot word write toward the region targets
//   WR_READY              target accepts the presented word
//   REGION_LOADED         per-region "all bytes received" flags
//   DROP_COUNT            saturating count of bytes matching no region
//   DONE                  single-cycle end-of-download pulse
module rom_region_loader #(
    parameter int NUM_REGIONS    = 8,
    parameter int BYTES_PER_WORD = 1,
    parameter int ADDR_W         = 25,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END  = '0
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        DL_ACTIVE,
    input  logic                        DL_WR,
    input  logic [ADDR_W-1:0]           DL_ADDR,
    input  logic [7:0]                  DL_DATA,
    output logic                        DL_WAIT,
    output logic [NUM_REGIONS-1:0]      WR_EN,
    output logic [ADDR_W-1:0]           WR_ADDR,
    output logic [8*BYTES_PER_WORD-1:0] WR_DATA,
    output logic [BYTES_PER_WORD-1:0]   WR_MASK,
    input  logic                        WR_READY,
    output logic [NUM_REGIONS-1:0]      REGION_LOADED,
    output logic [15:0]                 DROP_COUNT,
    output logic                        DONE
);

    localparam int IDX_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int LANE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BYTES_PER_WORD-1:0] MASK_FULL = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_FLUSH,
        S_FIN
    } state_t;

    state_t                        state, state_nx;
    logic                          active_q;
    logic [BYTES_PER_WORD-1:0]     mask, mask_nx;
    logic [8*BYTES_PER_WORD-1:0]   data, data_nx;
    logic [IDX_W-1:0]              held_idx;
    logic [ADDR_W-1:0]             held_word;
    logic [ADDR_W-1:0]             cnt [NUM_REGIONS];
    logic [NUM_REGIONS-1:0]        loaded;
    logic [15:0]                   drops;

    // Address decode. Scanning from the top index down lets the lowest
    // matching region overwrite higher ones, so overlaps resolve to it.
    logic                          hit;
    logic [IDX_W-1:0]              hit_idx;
    logic [ADDR_W-1:0]             offset;
    logic [LANE_W-1:0]             lane;
    logic [ADDR_W-1:0]             word;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        offset  = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (DL_ADDR >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                DL_ADDR <  REGION_END[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                offset  = DL_ADDR - REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
        lane = LANE_W'(offset % ADDR_W'(BYTES_PER_WORD));
        word = offset / ADDR_W'(BYTES_PER_WORD);
    end

    // A matched byte for a different word than the one being assembled must
    // wait until the partial word has been written out.
    logic conflict;
    logic accept;
    logic start;
    logic issuing;

    assign conflict = (state == S_COLLECT) && DL_WR && hit && (mask != '0) &&
                      ((hit_idx != held_idx) || (word != held_word));
    assign DL_WAIT  = (state == S_ISSUE) || (state == S_FLUSH) ||
                      (state == S_FIN) || conflict;
    assign accept   = (state == S_COLLECT) && DL_WR && !DL_WAIT;
    assign start    = (state == S_IDLE) && DL_ACTIVE && !active_q;
    assign issuing  = (state == S_ISSUE) || (state == S_FLUSH);

    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        data_nx  = data;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_COLLECT;
            end
            S_COLLECT: begin
                if (accept && hit) begin
                    data_nx[8*int'(lane) +: 8] = DL_DATA;
                    mask_nx[lane]              = 1'b1;
                end
                if (conflict || mask_nx == MASK_FULL)
                    state_nx = DL_ACTIVE ? S_ISSUE : S_FLUSH;
                else if (!DL_ACTIVE)
                    state_nx = (mask_nx != '0) ? S_FLUSH : S_FIN;
            end
            S_ISSUE, S_FLUSH: begin
                if (WR_READY) begin
                    mask_nx  = '0;
                    data_nx  = '0;
                    state_nx = (state == S_ISSUE) ? S_COLLECT : S_FIN;
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            active_q  <= 1'b0;
            mask      <= '0;
            data      <= '0;
            held_idx  <= '0;
            held_word <= '0;
            drops     <= '0;
        end else begin
            state    <= state_nx;
            active_q <= DL_ACTIVE;
            if (start) begin
                mask  <= '0;
                data  <= '0;
                drops <= '0;
            end else begin
                mask <= mask_nx;
                data <= data_nx;
                if (accept && !hit && drops != 16'hFFFF)
                    drops <= drops + 16'd1;
            end
            // First byte of a new word fixes which region/word is being built.
            if (accept && hit && mask == '0) begin
                held_idx  <= hit_idx;
                held_word <= word;
            end
        end
    end

    // Per-region byte counters; a region is loaded once it has received
    // exactly as many bytes as it spans.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            loaded <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) cnt[i] <= '0;
        end else if (start) begin
            loaded <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) cnt[i] <= '0;
        end else if (accept && hit) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (hit_idx == IDX_W'(i)) begin
                    cnt[i] <= cnt[i] + ADDR_W'(1);
                    if (cnt[i] + ADDR_W'(1) ==
                        REGION_END[i*ADDR_W +: ADDR_W] - REGION_BASE[i*ADDR_W +: ADDR_W])
                        loaded[i] <= 1'b1;
                end
            end
        end
    end

    assign WR_EN         = issuing ? (NUM_REGIONS'(1) << held_idx) : '0;
    assign WR_ADDR       = issuing ? held_word : '0;
    assign WR_DATA       = issuing ? data : '0;
    assign WR_MASK       = issuing ? mask : '0;
    assign REGION_LOADED = loaded;
    assign DROP_COUNT    = drops;
    assign DONE          = (state == S_FIN);

endmodule

// File: tb/tb_rom_region_loader.sv
module tb_rom_region_loader;

    localparam int NR = 3;
    localparam int BPW = 4;
    localparam int AW = 25;
    localparam logic [NR*AW-1:0] BASES = {25'h10000, 25'h00100, 25'h00000};
    localparam logic [NR*AW-1:0] ENDS  = {25'h10010, 25'h00200, 25'h00100};

    logic            CLK, RESET, DL_ACTIVE, DL_WR, DL_WAIT, WR_READY, DONE;
    logic [AW-1:0]   DL_ADDR, WR_ADDR;
    logic [7:0]      DL_DATA;
    logic [NR-1:0]   WR_EN, REGION_LOADED;
    logic [31:0]     WR_DATA;
    logic [3:0]      WR_MASK;
    logic [15:0]     DROP_COUNT;

    rom_region_loader #(
        .NUM_REGIONS(NR), .BYTES_PER_WORD(BPW), .ADDR_W(AW),
        .REGION_BASE(BASES), .REGION_END(ENDS)
    ) dut (
        .CLK(CLK), .RESET(RESET), .DL_ACTIVE(DL_ACTIVE), .DL_WR(DL_WR),
        .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA), .DL_WAIT(DL_WAIT),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_MASK(WR_MASK),
        .WR_READY(WR_READY), .REGION_LOADED(REGION_LOADED),
        .DROP_COUNT(DROP_COUNT), .DONE(DONE)
    );

    typedef struct packed {
        logic [NR-1:0] en;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    mask;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  done_cnt = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one comparison per completed word handshake.
    always @(negedge CLK) begin
        if (!RESET && WR_EN != '0 && WR_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected en=%b addr=%0h data=%0h mask=%b",
                         WR_EN, WR_ADDR, WR_DATA, WR_MASK);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (WR_EN !== e.en || WR_ADDR !== e.addr ||
                    WR_DATA !== e.data || WR_MASK !== e.mask) begin
                    errors++;
                    $display("FAIL write: got en=%b addr=%0h data=%0h mask=%b expected en=%b addr=%0h data=%0h mask=%b",
                             WR_EN, WR_ADDR, WR_DATA, WR_MASK, e.en, e.addr, e.data, e.mask);
                end
            end
        end
    end

    // DONE monitor: counts pulse cycles and checks no overlap with a write.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            done_cnt++;
            checks++;
            if (WR_EN !== '0) begin
                errors++;
                $display("FAIL done_overlap: got WR_EN=%b expected 0", WR_EN);
            end
        end
    end

    function automatic logic [7:0] fbyte(input int a);
        return 8'((a * 3 + 1) & 8'hFF);
    endfunction

    task automatic push(input logic [NR-1:0] en, input logic [AW-1:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
        wr_t w;
        w.en = en; w.addr = addr; w.data = data; w.mask = mask;
        exp_q.push_back(w);
    endtask

    // Presents one byte and returns how many cycles it took to be accepted.
    task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d, output int waited);
        logic acc;
        DL_WR = 1'b1; DL_ADDR = a; DL_DATA = d;
        waited = 0;
        acc = 1'b0;
        while (!acc && waited < 200) begin
            @(negedge CLK);
            acc = !DL_WAIT;
            @(posedge CLK);
            #1;
            waited++;
        end
        DL_WR = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte at %0h never accepted", a);
        end
    endtask

    task automatic start_dl();
        DL_ACTIVE = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic end_dl_wait_done();
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        DL_ACTIVE = 1'b0;
        n = 0;
        while (done_cnt == start_cnt && n < 100) begin
            @(posedge CLK);
            n++;
        end
        repeat (3) @(posedge CLK);
        #1;
        chk("done_pulses", 32'(done_cnt), 32'(start_cnt + 1));
    endtask

    initial begin
        int wt;
        int done_before;
        RESET = 1'b1; DL_ACTIVE = 1'b0; DL_WR = 1'b0; DL_ADDR = '0; DL_DATA = '0;
        WR_READY = 1'b1;
        #3;
        chk("rst_wr_en", 32'(WR_EN), 0);
        chk("rst_wr_addr", 32'(WR_ADDR), 0);
        chk("rst_wr_data", WR_DATA, 0);
        chk("rst_wr_mask", 32'(WR_MASK), 0);
        chk("rst_dl_wait", 32'(DL_WAIT), 0);
        chk("rst_loaded", 32'(REGION_LOADED), 0);
        chk("rst_drop", 32'(DROP_COUNT), 0);
        chk("rst_done", 32'(DONE), 0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Full stream over regions 0 and 1, target always ready.
        start_dl();
        for (int w = 0; w < 128; w++) begin
            push((w < 64) ? 3'b001 : 3'b010, AW'((w < 64) ? w : w - 64),
                 {fbyte(4*w+3), fbyte(4*w+2), fbyte(4*w+1), fbyte(4*w)}, 4'b1111);
            for (int b = 0; b < 4; b++) send_byte(AW'(4*w+b), fbyte(4*w+b), wt);
        end
        chk("stream_loaded", 32'(REGION_LOADED), 32'b011);
        end_dl_wait_done();
        chk("stream_q_empty", 32'(exp_q.size()), 0);
        chk("stream_drop", 32'(DROP_COUNT), 0);

        // Partial words flushed by a different word and by end of download.
        start_dl();
        chk("new_dl_loaded_clr", 32'(REGION_LOADED), 0);
        push(3'b001, 25'h4, 32'h0000BBAA, 4'b0011);
        send_byte(25'h10, 8'hAA, wt);
        send_byte(25'h11, 8'hBB, wt);
        push(3'b001, 25'h8, 32'h00000011, 4'b0001);
        send_byte(25'h20, 8'h11, wt);
        push(3'b010, 25'h0, 32'h005C0000, 4'b0100);
        send_byte(25'h102, 8'h5C, wt);
        end_dl_wait_done();
        chk("flush_q_empty", 32'(exp_q.size()), 0);

        // Dropped bytes, then a stalled word in region 2.
        start_dl();
        for (int i = 0; i < 3; i++) send_byte(AW'(25'h1F000 + i), 8'(8'hE0 + i), wt);
        @(posedge CLK);
        #1;
        chk("drop_count", 32'(DROP_COUNT), 3);
        WR_READY = 1'b0;
        push(3'b100, 25'h0, 32'h44332211, 4'b1111);
        send_byte(25'h10000, 8'h11, wt);
        send_byte(25'h10001, 8'h22, wt);
        send_byte(25'h10002, 8'h33, wt);
        send_byte(25'h10003, 8'h44, wt);
        DL_WR = 1'b1; DL_ADDR = 25'h10004; DL_DATA = 8'h55;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("stall_en", 32'(WR_EN), 32'b100);
            chk("stall_data", WR_DATA, 32'h44332211);
            chk("stall_addr", 32'(WR_ADDR), 0);
            chk("stall_wait", 32'(DL_WAIT), 1);
            @(posedge CLK);
            #1;
        end
        WR_READY = 1'b1;
        push(3'b100, 25'h1, 32'h00000055, 4'b0001);
        send_byte(25'h10004, 8'h55, wt);
        chk("stall_accept_cycles", 32'(wt), 2);
        end_dl_wait_done();
        chk("stall_q_empty", 32'(exp_q.size()), 0);
        start_dl();
        chk("drop_cleared", 32'(DROP_COUNT), 0);

        // Reset while a word is pending.
        WR_READY = 1'b0;
        for (int b = 0; b < 4; b++) send_byte(AW'(b), 8'(8'hC0 + b), wt);
        chk("pre_rst_en", 32'(WR_EN), 32'b001);
        #2 RESET = 1'b1; DL_ACTIVE = 1'b0;
        #1;
        chk("async_rst_en", 32'(WR_EN), 0);
        chk("async_rst_wait", 32'(DL_WAIT), 0);
        done_before = done_cnt;
        @(posedge CLK);
        #1 RESET = 1'b0;
        WR_READY = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        chk("post_rst_no_done", 32'(done_cnt), 32'(done_before));
        chk("post_rst_en", 32'(WR_EN), 0);
        chk("post_rst_loaded", 32'(REGION_LOADED), 0);
        // In IDLE a presented byte is ignored, so it cannot count as a drop.
        send_byte(25'h1F000, 8'h99, wt);
        @(posedge CLK);
        #1;
        chk("idle_ignores_byte", 32'(DROP_COUNT), 0);
        chk("final_q_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
